// File: rtl/clken_nco_gen.sv
// clken_nco_gen: NUM_CH fractional clock enables and ~50% square outputs from per-channel NCOs.
// Define CLKEN_NCO_PROG_EN to add runtime-programmable increments (wr_en/wr_ch/wr_inc/pend).
`timescale 1ns/1ps
module clken_nco_gen #(
   parameter int                      NUM_CH      = 3,
   parameter int                      ACC_W       = 32,
   parameter logic [NUM_CH*ACC_W-1:0] INC_VEC     = '0,
   parameter int                      LOCK_CYCLES = 1024
) (
   input  logic                                         refclk,
   input  logic                                         rst,
   input  logic [NUM_CH-1:0]                            ch_en,
   input  logic                                         sync,
`ifdef CLKEN_NCO_PROG_EN
   input  logic                                         wr_en,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
   input  logic [ACC_W-1:0]                             wr_inc,
   output logic [NUM_CH-1:0]                            pend,
`endif
   output logic [NUM_CH-1:0]                            ce_out,
   output logic [NUM_CH-1:0]                            clk_out,
   output logic                                         locked
);

`ifdef CLKEN_NCO_PROG_EN
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`endif
   localparam int             LCW      = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
   localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

   genvar g;
   for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] inc;
      logic [ACC_W:0]   sum;
      logic             run;
      logic             ce_q;
      logic             clk_q;

      assign run = ch_en[g] & ~sync;
      assign sum = {1'b0, acc} + {1'b0, inc};

      // Sync and disable both park the channel at phase 0, so re-enabling is deterministic.
      always_ff @(posedge refclk or posedge rst) begin
         if (rst) begin
            acc   <= '0;
            ce_q  <= 1'b0;
            clk_q <= 1'b0;
         end else if (run) begin
            acc   <= sum[ACC_W-1:0];
            ce_q  <= sum[ACC_W];
            clk_q <= sum[ACC_W-1];
         end else begin
            acc   <= '0;
            ce_q  <= 1'b0;
            clk_q <= 1'b0;
         end
      end

      assign ce_out[g]  = ce_q;
      assign clk_out[g] = clk_q;

`ifdef CLKEN_NCO_PROG_EN
      logic [ACC_W-1:0] pend_inc;
      logic             pend_q;
      logic             wr_hit;
      logic             xfer;

      // Retune only on a wrap (or while parked) so the running phase never glitches.
      assign wr_hit = wr_en && (wr_ch == CH_W'(g));
      assign xfer   = pend_q && (!run || sum[ACC_W]);

      always_ff @(posedge refclk or posedge rst) begin
         if (rst) begin
            inc      <= INC_VEC[g*ACC_W +: ACC_W];
            pend_inc <= '0;
            pend_q   <= 1'b0;
         end else begin
            if (xfer) inc <= pend_inc;
            if (wr_hit) begin
               pend_inc <= wr_inc;
               pend_q   <= 1'b1;
            end else if (xfer) begin
               pend_q   <= 1'b0;
            end
         end
      end

      assign pend[g] = pend_q;
`else
      assign inc = INC_VEC[g*ACC_W +: ACC_W];
`endif
   end

   logic [LCW-1:0] lock_cnt;
   logic [LCW-1:0] lock_cnt_nxt;

   always_comb begin
      lock_cnt_nxt = lock_cnt;
      if (lock_cnt != LOCK_MAX) lock_cnt_nxt = lock_cnt + LCW'(1);
   end

   // NOTE: next state is formed combinationally; the register only samples it with <=.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (sync) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         lock_cnt <= lock_cnt_nxt;
         locked   <= (lock_cnt_nxt == LOCK_MAX);
      end
   end

endmodule

// File: tb/tb_clken_nco_gen.sv
// Directed self-checking bench for clken_nco_gen: ACC_W=8, INC = {0, 96, 64}, LOCK_CYCLES=4.
`timescale 1ns/1ps
module tb_clken_nco_gen;
   localparam int          NUM_CH      = 3;
   localparam int          ACC_W       = 8;
   localparam int          LOCK_CYCLES = 4;
   localparam logic [23:0] INC_VEC     = {8'd0, 8'd96, 8'd64};

   logic        refclk = 1'b0;
   logic        rst    = 1'b1;
   logic        sync   = 1'b0;
   logic [2:0]  ch_en  = 3'b111;
   logic [2:0]  ce_out;
   logic [2:0]  clk_out;
   logic        locked;
`ifdef CLKEN_NCO_PROG_EN
   logic        wr_en  = 1'b0;
   logic [1:0]  wr_ch  = 2'd0;
   logic [7:0]  wr_inc = 8'd0;
   logic [2:0]  pend;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 refclk = ~refclk;

   clken_nco_gen #(
      .NUM_CH(NUM_CH), .ACC_W(ACC_W), .INC_VEC(INC_VEC), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .ch_en(ch_en),
      .sync(sync),
`ifdef CLKEN_NCO_PROG_EN
      .wr_en(wr_en),
      .wr_ch(wr_ch),
      .wr_inc(wr_inc),
      .pend(pend),
`endif
      .ce_out(ce_out),
      .clk_out(clk_out),
      .locked(locked)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Channel 0 (INC=64): wrap every 4th accumulation, MSB high on phases 2 and 3.
   function automatic logic ce0_exp(input int n);
      return (n % 4) == 0;
   endfunction
   function automatic logic clk0_exp(input int n);
      return (n % 4) >= 2;
   endfunction
   // Channel 1 (INC=96): carry iff the new phase is below the increment.
   function automatic logic ce1_exp(input int n);
      return ((96 * n) % 256) < 96;
   endfunction
   function automatic logic clk1_exp(input int n);
      return ((96 * n) % 256) >= 128;
   endfunction

   initial begin
      int ce1_cnt;
      int clk1_hi;
      int adj;
      int ch2_hi;
      logic prev;

      // Reset state
      tick();
      tick();
      check("rst_ce_out", ce_out, 3'b000);
      check("rst_clk_out", clk_out, 3'b000);
      check("rst_locked", locked, 1'b0);

      // Basic cadence, lock rise, and 512-cycle pulse statistics
      rst = 1'b0;
      ce1_cnt = 0; clk1_hi = 0; adj = 0; ch2_hi = 0; prev = 1'b0;
      for (int n = 1; n <= 512; n++) begin
         tick();
         if (n <= 16) begin
            check("t1_ce0", ce_out[0], ce0_exp(n));
            check("t1_clk0", clk_out[0], clk0_exp(n));
            check("t1_locked", locked, n >= LOCK_CYCLES);
            check("t2_ce1", ce_out[1], ce1_exp(n));
            check("t2_clk1", clk_out[1], clk1_exp(n));
         end
         if (ce_out[1]) ce1_cnt++;
         if (ce_out[1] && prev) adj++;
         prev = ce_out[1];
         if (clk_out[1]) clk1_hi++;
         if (ce_out[2] || clk_out[2]) ch2_hi++;
      end
      check("t2_ce1_count", ce1_cnt, 192);
      check("t2_ce1_adjacent", adj, 0);
      check("t2_clk1_high", clk1_hi, 256);
      check("t2_ch2_active", ch2_hi, 0);
      check("t2_locked", locked, 1'b1);

      // Sync on cycle 37, then ch_en[0] dropped for 10 cycles
      do_reset();
      for (int n = 1; n <= 36; n++) begin
         tick();
         check("t3_pre_ce0", ce_out[0], ce0_exp(n));
         check("t3_pre_clk0", clk_out[0], clk0_exp(n));
      end
      check("t3_pre_locked", locked, 1'b1);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("t3_sync_ce", ce_out, 3'b000);
      check("t3_sync_clk", clk_out, 3'b000);
      check("t3_sync_locked", locked, 1'b0);
      for (int m = 1; m <= 30; m++) begin
         tick();
         check("t3_locked", locked, m >= LOCK_CYCLES);
         check("t4_ce1", ce_out[1], ce1_exp(m));
         check("t4_clk1", clk_out[1], clk1_exp(m));
         check("t4_ce2", ce_out[2], 1'b0);
         if (m <= 8) begin
            check("t3_ce0", ce_out[0], ce0_exp(m));
            check("t3_clk0", clk_out[0], clk0_exp(m));
         end else if (m <= 18) begin
            check("t4_off_ce0", ce_out[0], 1'b0);
            check("t4_off_clk0", clk_out[0], 1'b0);
         end else begin
            check("t4_reen_ce0", ce_out[0], ce0_exp(m - 18));
            check("t4_reen_clk0", clk_out[0], clk0_exp(m - 18));
         end
         if (m == 8) ch_en[0] = 1'b0;
         if (m == 18) ch_en[0] = 1'b1;
      end

      // Asynchronous reset while ce_out[0] is high
      check("t5_pre_ce0", ce_out[0], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_ce", ce_out, 3'b000);
      check("t5_async_clk", clk_out, 3'b000);
      check("t5_async_locked", locked, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         tick();
         check("t5_rel_ce", ce_out, {1'b0, ce1_exp(n), ce0_exp(n)});
         check("t5_rel_locked", locked, n >= LOCK_CYCLES);
      end

`ifdef CLKEN_NCO_PROG_EN
      // Pending increment transfer on wrap, out-of-range write, transfer while disabled
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 8'd128;
      for (int n = 1; n <= 14; n++) begin
         tick();
         wr_en = 1'b0;
         check("t6_pend", pend, {(n >= 9 && n <= 10), 1'b0, (n <= 3)});
         check("t6_ce0", ce_out[0], (n <= 4) ? ce0_exp(n) : ((n % 2) == 0));
         check("t6_clk0", clk_out[0], (n <= 4) ? clk0_exp(n) : ((n % 2) == 1));
         check("t6_ce1", ce_out[1], ce1_exp(n));
         check("t6_ce2", ce_out[2], n == 13);
         check("t6_clk2", clk_out[2], (n == 12) || (n == 14));
         if (n == 6) begin
            wr_en = 1'b1; wr_ch = 2'd3; wr_inc = 8'd1;
         end
         if (n == 8) begin
            wr_en = 1'b1; wr_ch = 2'd2; wr_inc = 8'd128;
         end
         if (n == 10) ch_en[2] = 1'b0;
         if (n == 11) ch_en[2] = 1'b1;
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clken_nco_gen.md
Name: clken_nco_gen

Overview:
Parametrised successor to the fixed three-output clock generator. It produces NUM_CH independent fractional clock enables plus ~50% duty square outputs from one fast clock, using per-channel phase accumulators (NCO). Audio, CPU and sample-rate enables can be retuned without PLL regeneration. It adds behaviour the fixed generator lacks: per-channel gating, a global phase resync, and a lock indication after a programmable warm-up.

Parameters:
NUM_CH, 3, number of output channels (1..16)
ACC_W, 32, phase accumulator width in bits (8..48)
INC_VEC, {NUM_CH{32'h0}}, packed NUM_CH*ACC_W reset increments; channel i uses INC_VEC[i*ACC_W +: ACC_W]; f_ce(i) = f_refclk * INC_i / 2^ACC_W
LOCK_CYCLES, 1024, refclk cycles after reset release or sync before locked asserts (0..2^20)

Ports:
refclk  in  1  sole clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
ch_en  in  NUM_CH  per-channel run enable
sync  in  1  single-cycle pulse; realigns all channels to phase 0
ce_out  out  NUM_CH  one-cycle clock-enable pulses, registered
clk_out  out  NUM_CH  square outputs, registered (accumulator MSB)
locked  out  1  high once outputs are stable

Behaviour:
- Reset, asserted asynchronously:
  - all accumulators = 0; ce_out = 0, clk_out = 0, locked = 0; lock counter = 0.
  - Increment registers = INC_VEC.
- Per channel i, each refclk edge, priority order:
  - (1) sync = 1: acc_i <= 0, ce_out[i] <= 0, clk_out[i] <= 0.
  - (2) ch_en[i] = 0: acc_i <= 0, ce_out[i] <= 0, clk_out[i] <= 0. Re-enabling is phase-deterministic.
  - (3) Otherwise: {carry, acc_i} <= acc_i + INC_i (ACC_W+1-bit sum; carry discarded from the accumulator); ce_out[i] <= carry; clk_out[i] <= MSB of the new acc_i.
- Latency:
  - First accumulation occurs on the edge where ch_en[i] = 1 and sync = 0.
  - ce_out asserts on the same edge the wrap is computed (registered output, no extra pipeline).
- Any N·2^ACC_W-cycle window contains exactly N·INC_i ce pulses. Pulses are never adjacent unless INC_i > 2^(ACC_W-1).
- Boundaries:
  - INC_i = 0: ce_out[i] and clk_out[i] stay 0.
  - INC_i = 2^(ACC_W-1): ce every 2nd cycle; clk_out toggles every cycle.
  - INC_i > 2^(ACC_W-1): legal for ce_out. clk_out[i] is then undefined duty and must not be used as a clock.
  - Accumulator wrap is modular; no saturation.
- Lock counter:
  - Counts refclk cycles from reset release or from the cycle after sync, saturating at LOCK_CYCLES.
  - locked = 1 when count == LOCK_CYCLES.
  - sync clears the counter and locked on the same edge.
  - ch_en does not affect locked.
  - LOCK_CYCLES = 0: locked rises on the first edge after reset release or after sync.
- Reset mid-operation: immediate return to reset values; no pulse is emitted on release.

Optional Feature:
Macro CLKEN_NCO_PROG_EN.
- Defined: adds ports wr_en (in, 1), wr_ch (in, clog2(NUM_CH)), wr_inc (in, ACC_W), pend (out, NUM_CH).
- wr_en = 1 loads a pending increment for channel wr_ch and sets pend[wr_ch].
- The pending value is transferred to INC_i on that channel's next carry edge, or immediately if ch_en[i] = 0 or sync = 1. pend[i] then clears the following cycle.
- A second write before transfer overwrites the pending value.
- Writes with wr_ch ≥ NUM_CH are ignored.
- Reset clears pend and restores INC_VEC.
- Undefined: increments are fixed at INC_VEC; the ports are absent.

Test Plan:
1. ACC_W=8, INC0=64, ch_en=1, LOCK_CYCLES=4 → ce_out[0] high every 4th cycle starting cycle 4; clk_out[0] pattern 0,0,1,1 (period 4 cycles); locked rises 4 cycles after reset release.
2. ACC_W=8, INC1=96, run 512 cycles → exactly 192 ce_out[1] pulses, no two adjacent; INC2=0 → ce_out[2] never asserts.
3. Pulse sync mid-run on cycle 37 → all acc=0, ce_out/clk_out = 0 next cycle, locked low for exactly LOCK_CYCLES cycles, channels restart aligned (ce_out[0] 4 cycles after sync).
4. Drop ch_en[0] for 10 cycles → ce_out[0] = clk_out[0] = 0 throughout; the other channels are unaffected; on re-enable the first ce arrives after 4 cycles.
5. Assert rst asynchronously between edges during an active ce pulse → ce_out, clk_out, locked go 0 immediately; no pulse on release.
6. CLKEN_NCO_PROG_EN defined: write wr_ch=0, wr_inc=128 while INC0=64 → pend[0]=1 until the next ce_out[0]; subsequent pulses every 2 cycles; write with wr_ch=3 (NUM_CH=3) has no effect.
